// File: rtl/output_serializer.sv
// Captures four-channel network results into a small FIFO and replays them one
// channel word at a time over a valid/ready stream, dropping and flagging overflows.
module output_serializer #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             in_d0,
    input  logic [W-1:0]             in_d1,
    input  logic [W-1:0]             in_d2,
    input  logic [W-1:0]             in_d3,
    input  logic                     in_v,
    output logic [W-1:0]             out_data,
    output logic [1:0]               out_ch,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state;
    logic [4*W-1:0]    mem [DEPTH];
    logic [W-1:0]      hold [4];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [4*W-1:0]    head;
    logic              pop;
    logic              write;
    logic              drop;
    logic [1:0]        next_ch;

    assign head    = mem[rd_ptr];
    // A pop frees a slot on the same edge, so a full FIFO can still accept a write then.
    assign pop     = (count != '0) &&
                     ((state == IDLE) || (state == EMIT && out_ready && out_ch == 2'd3));
    assign write   = in_v && ((count < FULL) || pop);
    assign drop    = in_v && !write;
    assign next_ch = out_ch + 2'd1;

    always_ff @(posedge clk) begin
        if (write)
            mem[wr_ptr] <= {in_d3, in_d2, in_d1, in_d0};
        if (pop)
            for (int i = 0; i < 4; i++)
                hold[i] <= head[i*W +: W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_ch    <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (write)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({write, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            // A drop wins over a clear on the same edge so no loss goes unreported.
            if (drop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_ch    <= 2'd0;
                        out_last  <= 1'b0;
                        out_data  <= head[W-1:0];
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_ch != 2'd3) begin
                            out_ch   <= next_ch;
                            out_last <= (next_ch == 2'd3);
                            out_data <= hold[next_ch];
                        end else if (pop) begin
                            out_ch   <= 2'd0;
                            out_last <= 1'b0;
                            out_data <= head[W-1:0];
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: table of single results plus hand-written
// sequences for reset, backpressure, overflow, push/pop at full and pointer wrap.
module tb_output_serializer;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in_d0 = '0;
    logic [W-1:0]  in_d1 = '0;
    logic [W-1:0]  in_d2 = '0;
    logic [W-1:0]  in_d3 = '0;
    logic          in_v = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    out_ch;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    count;
    logic          overflow;
    logic          clear_ovf = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] d   [4];
        logic [15:0] exp [4];
    } vec_t;

    vec_t        vecs [3];
    logic [15:0] exp_q [$];

    output_serializer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .in_d3     (in_d3),
        .in_v      (in_v),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; presents one result for exactly one rising edge.
    task automatic apply_stimulus(input logic [15:0] d0, input logic [15:0] d1,
                                  input logic [15:0] d2, input logic [15:0] d3);
        in_d0 = d0;
        in_d1 = d1;
        in_d2 = d2;
        in_d3 = d3;
        in_v  = 1'b1;
        @(negedge clk);
        in_v  = 1'b0;
    endtask

    // Consumes exp_q from the stream; mode 1 drives ready as 1,0,0,1 repeating.
    task automatic drain(input int mode, input int budget);
        int k   = 0;
        int cyc = 0;
        logic rdy;
        while (k < exp_q.size() && cyc < budget) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (out_valid) begin
                check_output("stream_data", out_data, exp_q[k]);
                check_output("stream_ch", out_ch, k % 4);
                check_output("stream_last", out_last, (k % 4) == 3);
                if (rdy)
                    k++;
            end
            out_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        check_output("drain_complete", k, exp_q.size());
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0].d   = '{16'd100, 16'hFFFF, 16'h7FFF, 16'h8000};
        vecs[0].exp = '{16'd100, 16'hFFFF, 16'd32767, 16'h8000};
        vecs[1].d   = '{16'h1234, 16'h0000, 16'hFFFE, 16'h0001};
        vecs[1].exp = '{16'h1234, 16'd0, 16'hFFFE, 16'd1};
        vecs[2].d   = '{16'hFF9C, 16'h5555, 16'hAAAA, 16'h0F0F};
        vecs[2].exp = '{16'hFF9C, 16'h5555, 16'hAAAA, 16'h0F0F};

        #1;
        check_output("reset_valid", out_valid, 0);
        check_output("reset_count", count, 0);
        check_output("reset_data", out_data, 0);
        check_output("reset_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of a backpressured stream.
        out_ready = 1'b0;
        for (int n = 1; n <= 3; n++)
            apply_stimulus(16'(n * 7), 16'(n * 7 + 1), 16'(n * 7 + 2), 16'(n * 7 + 3));
        check_output("pre_reset_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check_output("async_reset_valid", out_valid, 0);
        check_output("async_reset_data", out_data, 0);
        check_output("async_reset_ch", out_ch, 0);
        check_output("async_reset_last", out_last, 0);
        check_output("async_reset_count", count, 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("post_reset_idle", out_valid, 0);
        end

        // Single results from the table, checking the two-edge latency and word order.
        for (int v = 0; v < 3; v++) begin
            out_ready = 1'b1;
            apply_stimulus(vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3]);
            check_output("lat_count", count, 1);
            check_output("lat_valid_low", out_valid, 0);
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                check_output("vec_valid", out_valid, 1);
                check_output("vec_ch", out_ch, c);
                check_output("vec_data", out_data, vecs[v].exp[c]);
                check_output("vec_last", out_last, c == 3);
                @(negedge clk);
            end
            check_output("vec_idle", out_valid, 0);
            check_output("vec_count", count, 0);
        end

        // Backpressure across two back-to-back results.
        out_ready = 1'b0;
        apply_stimulus(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        apply_stimulus(16'hF505, 16'hF606, 16'hF707, 16'hF808);
        exp_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404,
                  16'hF505, 16'hF606, 16'hF707, 16'hF808};
        drain(1, 100);
        check_output("bp_idle", out_valid, 0);

        // Overflow: six results with the sink stalled, then drop with a clear on the same edge.
        out_ready = 1'b0;
        for (int n = 1; n <= 6; n++)
            apply_stimulus(16'(n * 10), 16'(n * 10 + 1), 16'(n * 10 + 2), 16'(n * 10 + 3));
        check_output("ovf_set", overflow, 1);
        check_output("ovf_count", count, 4);
        check_output("ovf_head", out_data, 10);
        clear_ovf = 1'b1;
        apply_stimulus(16'd70, 16'd71, 16'd72, 16'd73);
        clear_ovf = 1'b0;
        check_output("ovf_drop_beats_clear", overflow, 1);
        check_output("ovf_count_held", count, 4);
        exp_q.delete();
        for (int n = 1; n <= 5; n++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back(16'(n * 10 + c));
        drain(0, 100);
        check_output("ovf_sticky", overflow, 1);
        check_output("ovf_drained", count, 0);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check_output("ovf_cleared", overflow, 0);

        // Write on the same edge as the ch3 handshake while full.
        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++)
            apply_stimulus(16'(n * 100), 16'(n * 100 + 1), 16'(n * 100 + 2), 16'(n * 100 + 3));
        check_output("full_count", count, 4);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_output("full_at_ch3", out_ch, 3);
        apply_stimulus(16'd600, 16'd601, 16'd602, 16'd603);
        check_output("pushpop_count", count, 4);
        check_output("pushpop_overflow", overflow, 0);
        check_output("pushpop_ch", out_ch, 0);
        check_output("pushpop_data", out_data, 200);
        exp_q.delete();
        for (int n = 2; n <= 6; n++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back(16'(n * 100 + c));
        drain(0, 100);
        check_output("pushpop_drained", count, 0);

        // Twenty results spaced six cycles apart, wrapping the pointers several times.
        exp_q.delete();
        for (int i = 0; i < 20; i++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back(16'(i * 4 + c) ^ 16'h8000);
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    apply_stimulus(16'(i * 4) ^ 16'h8000, 16'(i * 4 + 1) ^ 16'h8000,
                                   16'(i * 4 + 2) ^ 16'h8000, 16'(i * 4 + 3) ^ 16'h8000);
                    repeat (5) @(negedge clk);
                end
            end
            drain(0, 200);
        join
        check_output("wrap_overflow", overflow, 0);
        check_output("wrap_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
